// File: rtl/bridge_arb_pkg.sv
// bridge_arb_pkg: shared types and defaults for the bridge bus arbiter.
package bridge_arb_pkg;
    localparam int DEF_ADDR_W = 11;
    localparam int DEF_DATA_W = 16;
    localparam int DEF_BE_W   = DEF_DATA_W / 8;
    localparam logic [15:0] TIMEOUT_DATA = 16'hDEAD;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    typedef struct packed {
        logic                  rw;
        logic [DEF_ADDR_W-1:0] address;
        logic [DEF_BE_W-1:0]   byte_enable;
        logic [DEF_DATA_W-1:0] write_data;
    } req_t;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin grant; on a tie the requester not granted last wins.
module rr_arb2 (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    input  logic       update_i,
    output logic       valid_o,
    output logic       gnt_o
);
    logic last_q;
    always_comb begin
        valid_o = |req_i;
        gnt_o   = &req_i ? ~last_q : req_i[1];
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) last_q <= 1'b1;
        else if (update_i && valid_o) last_q <= gnt_o;
    end
endmodule

// File: rtl/bridge_bus_arbiter.sv
// bridge_bus_arbiter: shares the external bridge bus between two requesters (IDLE->BUSY->DONE).
// Define BRIDGE_ARB_TIMEOUT_EN to force completion after TIMEOUT_CYCLES unacknowledged BUSY cycles.
module bridge_bus_arbiter
    import bridge_arb_pkg::*;
#(
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int DATA_W         = DEF_DATA_W,
    parameter int BE_W           = DEF_BE_W,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk_clk,
    input  logic              reset_reset,
    input  logic              m0_bus_enable,
    input  logic              m0_rw,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic [BE_W-1:0]   m0_byte_enable,
    input  logic [DATA_W-1:0] m0_write_data,
    output logic              m0_acknowledge,
    output logic [DATA_W-1:0] m0_read_data,
    output logic              m0_irq,
    input  logic              m1_bus_enable,
    input  logic              m1_rw,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic [BE_W-1:0]   m1_byte_enable,
    input  logic [DATA_W-1:0] m1_write_data,
    output logic              m1_acknowledge,
    output logic [DATA_W-1:0] m1_read_data,
    output logic              s_bus_enable,
    output logic              s_rw,
    output logic [ADDR_W-1:0] s_address,
    output logic [BE_W-1:0]   s_byte_enable,
    output logic [DATA_W-1:0] s_write_data,
    input  logic              s_acknowledge,
    input  logic [DATA_W-1:0] s_read_data,
    input  logic              s_irq,
    output logic              err_timeout
);
    state_t state_q;
    logic   gnt_q, gnt, valid;
`ifdef BRIDGE_ARB_TIMEOUT_EN
    logic [7:0] cnt_q;
`else
    logic unused_timeout;
    assign unused_timeout = |TIMEOUT_CYCLES;
    assign err_timeout = 1'b0;
`endif
    rr_arb2 u_arb (
        .clk_i   (clk_clk),
        .rst_i   (reset_reset),
        .req_i   ({m1_bus_enable, m0_bus_enable}),
        .update_i(state_q == IDLE),
        .valid_o (valid),
        .gnt_o   (gnt)
    );
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state_q        <= IDLE;
            gnt_q          <= 1'b0;
            m0_acknowledge <= 1'b0;
            m1_acknowledge <= 1'b0;
            m0_read_data   <= '0;
            m1_read_data   <= '0;
            m0_irq         <= 1'b0;
            s_bus_enable   <= 1'b0;
            s_rw           <= 1'b0;
            s_address      <= '0;
            s_byte_enable  <= '0;
            s_write_data   <= '0;
`ifdef BRIDGE_ARB_TIMEOUT_EN
            cnt_q          <= '0;
            err_timeout    <= 1'b0;
`endif
        end else begin
            m0_irq         <= s_irq;
            m0_acknowledge <= 1'b0;
            m1_acknowledge <= 1'b0;
`ifdef BRIDGE_ARB_TIMEOUT_EN
            err_timeout    <= 1'b0;
`endif
            case (state_q)
                IDLE: if (valid) begin
                    state_q       <= BUSY;
                    gnt_q         <= gnt;
                    s_bus_enable  <= 1'b1;
                    s_rw          <= gnt ? m1_rw : m0_rw;
                    s_address     <= gnt ? m1_address : m0_address;
                    s_byte_enable <= gnt ? m1_byte_enable : m0_byte_enable;
                    s_write_data  <= gnt ? m1_write_data : m0_write_data;
`ifdef BRIDGE_ARB_TIMEOUT_EN
                    cnt_q         <= '0;
`endif
                end
                BUSY: if (s_acknowledge) begin
                    state_q        <= DONE;
                    s_bus_enable   <= 1'b0;
                    m0_acknowledge <= ~gnt_q;
                    m1_acknowledge <= gnt_q;
                    if (s_rw && !gnt_q) m0_read_data <= s_read_data;
                    if (s_rw && gnt_q) m1_read_data <= s_read_data;
                end
`ifdef BRIDGE_ARB_TIMEOUT_EN
                else if (cnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
                    state_q        <= DONE;
                    s_bus_enable   <= 1'b0;
                    m0_acknowledge <= ~gnt_q;
                    m1_acknowledge <= gnt_q;
                    err_timeout    <= 1'b1;
                    if (!gnt_q) m0_read_data <= DATA_W'(TIMEOUT_DATA);
                    if (gnt_q) m1_read_data <= DATA_W'(TIMEOUT_DATA);
                end else cnt_q <= cnt_q + 8'd1;
`endif
                // wait for the winner to release its request so it is not re-granted
                DONE: if (!(gnt_q ? m1_bus_enable : m0_bus_enable)) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bridge_bus_arbiter.sv
// tb_bridge_bus_arbiter: table-driven transactions checked through a grant/ack scoreboard.
module tb_bridge_bus_arbiter;
    import bridge_arb_pkg::*;
    localparam int TMO = 255;
    typedef struct {
        bit          m;
        req_t        r;
        logic [15:0] rd;
        int          dly;
        logic [15:0] exp_rd;
        bit          exp_err;
    } txn_t;
    logic clk = 0, rst = 1;
    logic m0_bus_enable = 0, m0_rw = 0, m0_acknowledge, m0_irq;
    logic [10:0] m0_address = 0;
    logic [1:0] m0_byte_enable = 0;
    logic [15:0] m0_write_data = 0, m0_read_data;
    logic m1_bus_enable = 0, m1_rw = 0, m1_acknowledge;
    logic [10:0] m1_address = 0;
    logic [1:0] m1_byte_enable = 0;
    logic [15:0] m1_write_data = 0, m1_read_data;
    logic s_bus_enable, s_rw, s_acknowledge = 0, s_irq = 0, err_timeout;
    logic [10:0] s_address;
    logic [1:0] s_byte_enable;
    logic [15:0] s_write_data, s_read_data = 0;
    int checks = 0, errors = 0;
    txn_t exp_q[$], ack_q[$];
    txn_t cur, a;
    bit skip_len = 0;
    always #5 clk = ~clk;
    bridge_bus_arbiter dut (
        .clk_clk(clk), .reset_reset(rst),
        .m0_bus_enable(m0_bus_enable), .m0_rw(m0_rw), .m0_address(m0_address),
        .m0_byte_enable(m0_byte_enable), .m0_write_data(m0_write_data),
        .m0_acknowledge(m0_acknowledge), .m0_read_data(m0_read_data), .m0_irq(m0_irq),
        .m1_bus_enable(m1_bus_enable), .m1_rw(m1_rw), .m1_address(m1_address),
        .m1_byte_enable(m1_byte_enable), .m1_write_data(m1_write_data),
        .m1_acknowledge(m1_acknowledge), .m1_read_data(m1_read_data),
        .s_bus_enable(s_bus_enable), .s_rw(s_rw), .s_address(s_address),
        .s_byte_enable(s_byte_enable), .s_write_data(s_write_data),
        .s_acknowledge(s_acknowledge), .s_read_data(s_read_data), .s_irq(s_irq),
        .err_timeout(err_timeout)
    );
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask
    function automatic txn_t mk(bit m, logic rw, logic [10:0] ad, logic [1:0] be, logic [15:0] wd,
                                logic [15:0] rd, int dly, logic [15:0] exp_rd, bit err);
        txn_t t;
        t.m = m; t.r.rw = rw; t.r.address = ad; t.r.byte_enable = be; t.r.write_data = wd;
        t.rd = rd; t.dly = dly; t.exp_rd = exp_rd; t.exp_err = err;
        return t;
    endfunction
    task automatic drive(input txn_t t, input int hold);
        logic seen = 0;
        if (t.m) begin
            m1_rw = t.r.rw; m1_address = t.r.address; m1_byte_enable = t.r.byte_enable;
            m1_write_data = t.r.write_data; m1_bus_enable = 1;
        end else begin
            m0_rw = t.r.rw; m0_address = t.r.address; m0_byte_enable = t.r.byte_enable;
            m0_write_data = t.r.write_data; m0_bus_enable = 1;
        end
        for (int i = 0; i < 600 && !seen; i++) begin
            @(negedge clk);
            seen = t.m ? m1_acknowledge : m0_acknowledge;
        end
        chk("ack_seen", seen, 1);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("held_no_regrant", s_bus_enable, 0);
        end
        if (t.m) m1_bus_enable = 0; else m0_bus_enable = 0;
        @(negedge clk);
    endtask
    // bus monitor followed by the slave model, one process so cur is updated before the slave uses it
    initial begin
        logic prev_sbe = 0;
        logic [1:0] prev_ack = 0, ackv;
        int len = 0, scnt = 0;
        forever begin
            @(negedge clk);
            if (s_bus_enable && !prev_sbe) begin
                chk("grant_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    cur = exp_q.pop_front();
                    chk("s_fields", {s_rw, s_address, s_byte_enable, s_write_data}, cur.r);
                    ack_q.push_back(cur);
                end
                len = 0;
            end else if (s_bus_enable)
                chk("s_stable", {s_rw, s_address, s_byte_enable, s_write_data}, cur.r);
            if (s_bus_enable) len++;
            if (!s_bus_enable && prev_sbe) begin
                if (skip_len) skip_len = 0;
                else chk("busy_len", len, cur.dly == 0 ? TMO : cur.dly);
            end
            ackv = {m1_acknowledge, m0_acknowledge};
            if (ackv != 0) begin
                chk("ack_expected", ack_q.size() != 0, 1);
                if (ack_q.size() != 0) begin
                    a = ack_q.pop_front();
                    chk("ack_owner", ackv, a.m ? 2'b10 : 2'b01);
                    chk("read_data", a.m ? m1_read_data : m0_read_data, a.exp_rd);
                    chk("err_timeout", err_timeout, a.exp_err);
                end
            end
            if (prev_ack != 0) chk("ack_pulse", ackv, 0);
            prev_ack = ackv;
            prev_sbe = s_bus_enable;
            if (s_bus_enable && !s_acknowledge) begin
                scnt++;
                if (cur.dly != 0 && scnt == cur.dly) begin
                    s_acknowledge = 1;
                    s_read_data = cur.r.rw ? cur.rd : 16'hBEEF;
                end
            end else begin
                s_acknowledge = 0;
                scnt = 0;
            end
        end
    end
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
    initial begin
        txn_t v[6], c[4], h0, h1, r0, r1;
        v[0] = mk(0, 1, 11'h012, 2'b11, 16'h0000, 16'hA5C3, 3, 16'hA5C3, 0);
        v[1] = mk(1, 0, 11'h7FF, 2'b10, 16'h1234, 16'h0000, 2, 16'h0000, 0);
        v[2] = mk(1, 1, 11'h155, 2'b01, 16'h0000, 16'h5A5A, 1, 16'h5A5A, 0);
        v[3] = mk(0, 0, 11'h000, 2'b11, 16'hFFFF, 16'h0000, 4, 16'hA5C3, 0);
        v[4] = mk(0, 1, 11'h400, 2'b11, 16'h0000, 16'h0F0F, 1, 16'h0F0F, 0);
        v[5] = mk(1, 0, 11'h2AA, 2'b01, 16'h00C3, 16'h0000, 5, 16'h5A5A, 0);
        c[0] = mk(0, 1, 11'h101, 2'b11, 16'h0000, 16'h1111, 1, 16'h1111, 0);
        c[1] = mk(1, 1, 11'h202, 2'b11, 16'h0000, 16'h2222, 1, 16'h2222, 0);
        c[2] = mk(0, 0, 11'h303, 2'b10, 16'hABCD, 16'h0000, 1, 16'h1111, 0);
        c[3] = mk(1, 1, 11'h404, 2'b01, 16'h0000, 16'h4444, 1, 16'h4444, 0);
        h0 = mk(0, 1, 11'h0AA, 2'b11, 16'h0000, 16'h7777, 2, 16'h7777, 0);
        h1 = mk(1, 1, 11'h0BB, 2'b11, 16'h0000, 16'h8888, 1, 16'h8888, 0);
        r0 = mk(0, 1, 11'h321, 2'b11, 16'h0000, 16'h9999, 1, 16'h9999, 0);
        r1 = mk(1, 0, 11'h432, 2'b11, 16'h5555, 16'h0000, 1, 16'h0000, 0);
        repeat (3) @(negedge clk);
        rst = 0;
        chk("reset_m", {m0_acknowledge, m0_read_data, m0_irq, m1_acknowledge, m1_read_data}, 0);
        chk("reset_s", {s_bus_enable, s_rw, s_address, s_byte_enable, s_write_data, err_timeout}, 0);
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(v[i]);
            drive(v[i], 0);
        end
        s_irq = 1;
        @(negedge clk);
        chk("m0_irq_set", m0_irq, 1);
        s_irq = 0;
        @(negedge clk);
        chk("m0_irq_clr", m0_irq, 0);
        for (int i = 0; i < 4; i++) exp_q.push_back(c[i]);
        fork
            begin drive(c[0], 0); drive(c[2], 0); end
            begin drive(c[1], 0); drive(c[3], 0); end
        join
        exp_q.push_back(h0);
        exp_q.push_back(h1);
        fork
            drive(h0, 2);
            drive(h1, 0);
        join
        exp_q.push_back(mk(0, 1, 11'h123, 2'b11, 16'h0000, 16'h0000, 20, 16'h0000, 0));
        m0_rw = 1; m0_address = 11'h123; m0_byte_enable = 2'b11; m0_bus_enable = 1;
        for (int i = 0; i < 20 && !s_bus_enable; i++) @(negedge clk);
        chk("busy_reached", s_bus_enable, 1);
        repeat (2) @(negedge clk);
        rst = 1;
        skip_len = 1;
        m0_bus_enable = 0;
        @(negedge clk);
        chk("midrst_m", {m0_acknowledge, m0_read_data, m0_irq, m1_acknowledge, m1_read_data}, 0);
        chk("midrst_s", {s_bus_enable, s_rw, s_address, s_byte_enable, s_write_data, err_timeout}, 0);
        ack_q.delete();
        rst = 0;
        exp_q.push_back(r0);
        exp_q.push_back(r1);
        fork
            drive(r0, 0);
            drive(r1, 0);
        join
`ifdef BRIDGE_ARB_TIMEOUT_EN
        exp_q.push_back(mk(1, 1, 11'h055, 2'b11, 16'h0000, 16'h0000, 0, 16'hDEAD, 1));
        drive(mk(1, 1, 11'h055, 2'b11, 16'h0000, 16'h0000, 0, 16'hDEAD, 1), 0);
`endif
        repeat (5) @(negedge clk);
        chk("queues_drained", exp_q.size() + ack_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
